alu_exec: RTL

- Registered execute-stage ALU. Consumes the 3-bit alu_control code from the ALU control decoder, plus two operands.
- Produces result, branch decision and flags behind a valid/ready handshake.
- Two-entry output buffer (output register + skid register): full throughput, no combinational ready path from out_ready to in_ready.
- Sits between decode/operand fetch and memory/writeback.

---
 rtl/alu_exec.sv | 116 +++++++++++
 1 files changed

// File: rtl/alu_exec.sv
// Registered execute-stage ALU with a two-entry output buffer (output + skid register).
// Define ALU_EXEC_SLL_EN to make code 111 a left shift; otherwise 111 is flagged illegal.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             branch_taken,
  output logic             zero,
  output logic             illegal
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             taken;
    logic             ill;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state_q, state_d;
  entry_t out_q, out_d, skid_q, skid_d, new_e;
  logic   in_ready_q;
  logic   accept, xfer;

`ifdef ALU_EXEC_SLL_EN
  localparam int SHW = $clog2(WIDTH);
`endif

  assign accept = in_valid && in_ready_q;
  assign xfer   = (state_q != EMPTY) && out_ready;

  // Operation evaluated at the input; only the finished entry is buffered.
  always_comb begin
    new_e = '0;
    case (alu_control)
      3'b000: new_e.res = a & b;
      3'b001: new_e.res = a | b;
      3'b010: new_e.res = a + b;
      3'b011: new_e.res = a - b;
      3'b100: new_e.taken = ($signed(a) < $signed(b));
      3'b101: new_e.taken = ($signed(a) >= $signed(b));
      3'b110: new_e.taken = (a == b);
      default: begin
`ifdef ALU_EXEC_SLL_EN
        new_e.res = a << b[SHW-1:0];
`else
        new_e.ill = 1'b1;
`endif
      end
    endcase
    if (alu_control[2] && (alu_control != 3'b111))
      new_e.res = {{(WIDTH-1){1'b0}}, new_e.taken};
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = new_e;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          out_d = new_e;
        end else if (accept) begin
          skid_d  = new_e;
          state_d = TWO;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (xfer) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q != EMPTY);
  assign result       = out_q.res;
  assign branch_taken = out_q.taken;
  assign illegal      = out_q.ill;
  assign zero         = ~|out_q.res;

endmodule
